// File: rtl/pcm_to_i2s_tx.sv
// PCM sample-pair to I2S serializer with a one-deep holding register; bit clock equals clk.
// Optional build macro TX_MONO_SUM_EN sends the averaged (left+right)>>>1 word in both slots.
module pcm_to_i2s_tx #(
    parameter int NUMBER_OF_BITS = 8,
    parameter int SLOT_BITS      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    input  logic [NUMBER_OF_BITS-1:0] sample_left,
    input  logic [NUMBER_OF_BITS-1:0] sample_right,
    output logic                      sd_out,
    output logic                      ws_out,
    output logic                      frame_start,
    output logic                      underrun
);

    localparam int NB = NUMBER_OF_BITS;
    localparam int CW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
    localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] CNT_LAST    = CW'(SLOT_BITS - 1);
    localparam logic [CW-1:0] CNT_MSB_END = CW'(NUMBER_OF_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_nxt_s;
    logic            boundary_s;
    logic            right_start_s;
    logic            in_word_s;
    logic            transfer_s;
    logic            holding_full_r;
    logic [NB-1:0]   hold_left_r;
    logic [NB-1:0]   hold_right_r;
    logic [NB-1:0]   sel_left_s;
    logic [NB-1:0]   sel_right_s;
    logic [NB-1:0]   word_left_s;
    logic [NB-1:0]   word_right_s;
    logic [NB-1:0]   tx_shift_r;
    logic [NB-1:0]   tx_right_r;
    logic            ws_nxt_s;
    logic            sd_nxt_s;
    logic            fs_nxt_s;

`ifdef TX_MONO_SUM_EN
    // Sign-extend both words, add, and keep bits [NB:1]: an arithmetic halving that cannot overflow.
    function automatic logic [NB-1:0] mono_mix(input logic [NB-1:0] l, input logic [NB-1:0] r);
        logic [NB:0] sum;
        sum = {l[NB-1], l} + {r[NB-1], r};
        return sum[NB:1];
    endfunction
`endif

    assign transfer_s   = sample_valid && !holding_full_r;
    assign sample_ready = !holding_full_r;

    // State register: FSM state and slot counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic; enable only matters in IDLE and at the end of RIGHT.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = CNT_ZERO;
                if (enable) begin
                    state_nxt_s = ST_LEFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LEFT: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_RIGHT;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_RIGHT: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_nxt_s = CNT_ZERO;
                    if (enable) begin
                        state_nxt_s = ST_LEFT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    assign boundary_s    = (state_nxt_s == ST_LEFT)  && (cnt_nxt_s == CNT_ZERO);
    assign right_start_s = (state_nxt_s == ST_RIGHT) && (cnt_nxt_s == CNT_ZERO);
    assign in_word_s     = (state_nxt_s != ST_IDLE) && (cnt_nxt_s >= CNT_ONE)
                           && (cnt_nxt_s <= CNT_MSB_END);

    // Output decode of the upcoming cycle, so ws and the slot's first bit change together.
    always_comb begin
        ws_nxt_s = 1'b0;
        sd_nxt_s = 1'b0;
        fs_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                ws_nxt_s = 1'b0;
                sd_nxt_s = 1'b0;
                fs_nxt_s = 1'b0;
            end
            ST_LEFT: begin
                ws_nxt_s = 1'b0;
                sd_nxt_s = in_word_s ? tx_shift_r[NB-1] : 1'b0;
                fs_nxt_s = boundary_s;
            end
            ST_RIGHT: begin
                ws_nxt_s = 1'b1;
                sd_nxt_s = in_word_s ? tx_shift_r[NB-1] : 1'b0;
                fs_nxt_s = 1'b0;
            end
            default: begin
                ws_nxt_s = 1'b0;
                sd_nxt_s = 1'b0;
                fs_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered serial outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            ws_out      <= 1'b0;
            sd_out      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            ws_out      <= ws_nxt_s;
            sd_out      <= sd_nxt_s;
            frame_start <= fs_nxt_s;
        end
    end

    // Frame-boundary source: holding pair, else a same-cycle transfer, else silence.
    always_comb begin
        sel_left_s  = {NB{1'b0}};
        sel_right_s = {NB{1'b0}};
        if (holding_full_r) begin
            sel_left_s  = hold_left_r;
            sel_right_s = hold_right_r;
        end else if (transfer_s) begin
            sel_left_s  = sample_left;
            sel_right_s = sample_right;
        end else begin
            sel_left_s  = {NB{1'b0}};
            sel_right_s = {NB{1'b0}};
        end
    end

`ifdef TX_MONO_SUM_EN
    assign word_left_s  = mono_mix(sel_left_s, sel_right_s);
    assign word_right_s = word_left_s;
`else
    assign word_left_s  = sel_left_s;
    assign word_right_s = sel_right_s;
`endif

    // Holding register; a boundary always leaves it empty (consumed or bypassed).
    always_ff @(posedge clk) begin
        if (reset) begin
            holding_full_r <= 1'b0;
            hold_left_r    <= {NB{1'b0}};
            hold_right_r   <= {NB{1'b0}};
        end else if (boundary_s) begin
            holding_full_r <= 1'b0;
        end else if (transfer_s) begin
            holding_full_r <= 1'b1;
            hold_left_r    <= sample_left;
            hold_right_r   <= sample_right;
        end else begin
            holding_full_r <= holding_full_r;
        end
    end

    // Transmit registers: shifter reloads at each slot start and shifts through the word bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_shift_r <= {NB{1'b0}};
            tx_right_r <= {NB{1'b0}};
        end else if (boundary_s) begin
            tx_shift_r <= word_left_s;
            tx_right_r <= word_right_s;
        end else if (right_start_s) begin
            tx_shift_r <= tx_right_r;
        end else if (in_word_s) begin
            tx_shift_r <= {tx_shift_r[NB-2:0], 1'b0};
        end else begin
            tx_shift_r <= tx_shift_r;
        end
    end

    // Sticky underrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun <= 1'b0;
        end else if (boundary_s && !holding_full_r && !transfer_s) begin
            underrun <= 1'b1;
        end else begin
            underrun <= underrun;
        end
    end

endmodule

// File: tb/tb_pcm_to_i2s_tx.sv
// Scoreboard bench for pcm_to_i2s_tx (NUMBER_OF_BITS=8, SLOT_BITS=16): expected
// {frame_start, ws, sd} per cycle are queued when pairs are supplied and popped each cycle.
module tb_pcm_to_i2s_tx;

    localparam int NB = 8;
    localparam int SB = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          sample_valid;
    logic          sample_ready;
    logic [NB-1:0] sample_left;
    logic [NB-1:0] sample_right;
    logic          sd_out;
    logic          ws_out;
    logic          frame_start;
    logic          underrun;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] exp_q[$];

    pcm_to_i2s_tx #(.NUMBER_OF_BITS(NB), .SLOT_BITS(SB)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_left(sample_left), .sample_right(sample_right),
        .sd_out(sd_out), .ws_out(ws_out), .frame_start(frame_start), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected 32-cycle frame for a pair, including the optional mono mix.
    function automatic void push_frame(input logic [NB-1:0] l, input logic [NB-1:0] r);
        logic [NB-1:0] w;
        logic [NB-1:0] tmp;
        logic [NB:0]   sum;
        logic          sdb;
        int            k;
`ifdef TX_MONO_SUM_EN
        sum = $signed({l[NB-1], l}) + $signed({r[NB-1], r});
        l = sum[NB:1];
        r = sum[NB:1];
`else
        sum = '0;
`endif
        for (int c = 0; c < 2 * SB; c++) begin
            w   = (c < SB) ? l : r;
            k   = c % SB;
            tmp = w << (k - 1);
            sdb = (k >= 1 && k <= NB) ? tmp[NB-1] : 1'b0;
            exp_q.push_back({(c == 0), (c >= SB), sdb});
        end
    endfunction

    function automatic void push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(3'b000);
    endfunction

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; sample_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; sample_valid = 1'b0;
        sample_left = 8'h00; sample_right = 8'h00;
        repeat (3) tick();
        n_checks++;
        if ({frame_start, ws_out, sd_out, sample_ready, underrun} !== 5'b00010) begin
            n_fail++;
            $display("FAIL reset_state: got fs/ws/sd/ready/underrun=%05b, required 00010",
                     {frame_start, ws_out, sd_out, sample_ready, underrun});
        end
        reset = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({frame_start, ws_out, sd_out, sample_ready, underrun} !== 5'b00010) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %05b, required 00010",
                     {frame_start, ws_out, sd_out, sample_ready, underrun});
        end
    endtask

    // Pair loaded while idle, then enable raised; enable dropped at LEFT cycle 5.
    task automatic test_basic();
        logic [2:0] e;
        sample_left = 8'hA5; sample_right = 8'h3C; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        n_checks++;
        if (sample_ready !== 1'b0) begin
            n_fail++; $display("FAIL basic_hold_ready: got %0b, required 0", sample_ready);
        end
        enable = 1'b1;
        push_frame(8'hA5, 8'h3C);
        push_idle(3);
        for (int i = 0; i < 35; i++) begin
            tick();
            if (i == 5) enable = 1'b0;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL basic_queue: scoreboard empty at cycle %0d", i);
            end else begin
                e = exp_q.pop_front();
                if ({frame_start, ws_out, sd_out} !== e) begin
                    n_fail++;
                    $display("FAIL basic_stream cycle %0d: got fs/ws/sd=%03b, required %03b",
                             i, {frame_start, ws_out, sd_out}, e);
                end
            end
        end
        n_checks++;
        if ({sample_ready, underrun} !== 2'b10) begin
            n_fail++; $display("FAIL basic_end_flags: got ready/underrun=%02b, required 10",
                               {sample_ready, underrun});
        end
    endtask

    // Second boundary with no sample: silent frame and sticky underrun until reset.
    task automatic test_underrun();
        logic [2:0] e;
        do_reset();
        sample_left = 8'h5A; sample_right = 8'hC3; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        enable = 1'b1;
        push_frame(8'h5A, 8'hC3);
        push_frame(8'h00, 8'h00);
        push_idle(2);
        for (int i = 0; i < 66; i++) begin
            tick();
            if (i == 37) enable = 1'b0;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL underrun_queue: scoreboard empty at cycle %0d", i);
            end else begin
                e = exp_q.pop_front();
                if ({frame_start, ws_out, sd_out} !== e) begin
                    n_fail++;
                    $display("FAIL underrun_stream cycle %0d: got %03b, required %03b",
                             i, {frame_start, ws_out, sd_out}, e);
                end
            end
            if (i == 31 || i == 32) begin
                n_checks++;
                if (underrun !== (i == 32)) begin
                    n_fail++; $display("FAIL underrun_flag cycle %0d: got %0b, required %0b",
                                       i, underrun, (i == 32));
                end
            end
        end
        repeat (5) tick();
        n_checks++;
        if (underrun !== 1'b1) begin
            n_fail++; $display("FAIL underrun_sticky: got %0b, required 1", underrun);
        end
        do_reset();
        n_checks++;
        if (underrun !== 1'b0) begin
            n_fail++; $display("FAIL underrun_cleared: got %0b, required 0", underrun);
        end
    endtask

    // Transfers landing exactly on boundary edges with holding empty (IDLE entry and RIGHT->LEFT).
    task automatic test_boundary_transfer();
        logic [2:0] e;
        do_reset();
        enable = 1'b1; sample_valid = 1'b1;
        sample_left = 8'h81; sample_right = 8'h7E;
        push_frame(8'h81, 8'h7E);
        for (int i = 0; i < 66; i++) begin
            tick();
            if (i == 37) enable = 1'b0;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL boundary_queue: scoreboard empty at cycle %0d", i);
            end else begin
                e = exp_q.pop_front();
                if ({frame_start, ws_out, sd_out} !== e) begin
                    n_fail++;
                    $display("FAIL boundary_stream cycle %0d: got %03b, required %03b",
                             i, {frame_start, ws_out, sd_out}, e);
                end
            end
            if (i == 0 || i == 32) begin
                sample_valid = 1'b0;
                n_checks++;
                if ({sample_ready, underrun} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL boundary_flags cycle %0d: got ready/underrun=%02b, required 10",
                             i, {sample_ready, underrun});
                end
            end
            if (i == 31) begin
                sample_valid = 1'b1; sample_left = 8'h12; sample_right = 8'hF0;
                push_frame(8'h12, 8'hF0);
                push_idle(2);
            end
        end
    endtask

    // Three consecutive frames, next pair supplied mid-frame into holding.
    task automatic test_back_to_back();
        logic [2:0]    e;
        logic [NB-1:0] pl[3];
        logic [NB-1:0] pr[3];
        pl[0] = 8'h7F; pr[0] = 8'h01;
        pl[1] = 8'h80; pr[1] = 8'h80;
        pl[2] = 8'h80; pr[2] = 8'h7F;
        do_reset();
        sample_left = pl[0]; sample_right = pr[0]; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        enable = 1'b1;
        push_frame(pl[0], pr[0]);
        for (int i = 0; i < 98; i++) begin
            tick();
            if (i == 67) enable = 1'b0;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL b2b_queue: scoreboard empty at cycle %0d", i);
            end else begin
                e = exp_q.pop_front();
                if ({frame_start, ws_out, sd_out} !== e) begin
                    n_fail++;
                    $display("FAIL b2b_stream cycle %0d: got %03b, required %03b",
                             i, {frame_start, ws_out, sd_out}, e);
                end
            end
            if (i == 10 || i == 42) begin
                sample_valid = 1'b1;
                sample_left  = pl[i / 32 + 1];
                sample_right = pr[i / 32 + 1];
                push_frame(pl[i / 32 + 1], pr[i / 32 + 1]);
            end
            if (i == 11 || i == 43) begin
                sample_valid = 1'b0;
                n_checks++;
                if (sample_ready !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_ready cycle %0d: got %0b, required 0", i, sample_ready);
                end
            end
            if (i == 64) push_idle(2);
        end
        n_checks++;
        if ({sample_ready, underrun} !== 2'b10) begin
            n_fail++; $display("FAIL b2b_end_flags: got ready/underrun=%02b, required 10",
                               {sample_ready, underrun});
        end
    endtask

    // Reset asserted at RIGHT cnt 7 with underrun set and holding full.
    task automatic test_reset_mid();
        logic [2:0] e;
        do_reset();
        enable = 1'b1;
        push_frame(8'h00, 8'h00);
        for (int i = 0; i < 56; i++) begin
            tick();
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL rstmid_queue: scoreboard empty at cycle %0d", i);
            end else begin
                e = exp_q.pop_front();
                if ({frame_start, ws_out, sd_out} !== e) begin
                    n_fail++;
                    $display("FAIL rstmid_stream cycle %0d: got %03b, required %03b",
                             i, {frame_start, ws_out, sd_out}, e);
                end
            end
            if (i == 5 || i == 40) begin
                sample_valid = 1'b1; sample_left = 8'h6B; sample_right = 8'hFF;
                if (i == 5) push_frame(8'h6B, 8'hFF);
            end
            if (i == 6 || i == 41) sample_valid = 1'b0;
        end
        n_checks++;
        if ({sample_ready, underrun} !== 2'b01) begin
            n_fail++; $display("FAIL rstmid_before: got ready/underrun=%02b, required 01",
                               {sample_ready, underrun});
        end
        reset = 1'b1; enable = 1'b0;
        tick();
        n_checks++;
        if ({frame_start, ws_out, sd_out, sample_ready, underrun} !== 5'b00010) begin
            n_fail++;
            $display("FAIL rstmid_after: got fs/ws/sd/ready/underrun=%05b, required 00010",
                     {frame_start, ws_out, sd_out, sample_ready, underrun});
        end
        reset = 1'b0;
        exp_q.delete();
        repeat (3) tick();
        n_checks++;
        if ({frame_start, ws_out, sd_out} !== 3'b000) begin
            n_fail++; $display("FAIL rstmid_idle: got %03b, required 000", {frame_start, ws_out, sd_out});
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; sample_valid = 1'b0;
        sample_left = 8'h00; sample_right = 8'h00;
        test_reset();
        test_basic();
        test_underrun();
        test_boundary_transfer();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pcm_to_i2s_tx.md
PCM_TO_I2S_TX -- requirements
Module: pcm_to_i2s_tx

Interface
REQ-001 SHALL have parameter NUMBER_OF_BITS, default 8: PCM sample width in bits, two's complement.
REQ-002 SHALL have parameter SLOT_BITS, default 16: clk cycles per I2S slot; legal only if SLOT_BITS >= NUMBER_OF_BITS+1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; the I2S bit clock equals clk.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: run request, sampled only in IDLE and at frame boundaries.
REQ-006 SHALL have port sample_valid, input, 1 bit: a sample pair is presented.
REQ-007 SHALL have port sample_ready, output, 1 bit: holding register is empty.
REQ-008 SHALL have port sample_left, input, NUMBER_OF_BITS bits: left-slot PCM word.
REQ-009 SHALL have port sample_right, input, NUMBER_OF_BITS bits: right-slot PCM word.
REQ-010 SHALL have port sd_out, output, 1 bit: registered serial I2S data.
REQ-011 SHALL have port ws_out, output, 1 bit: registered word select (0 = left, 1 = right).
REQ-012 SHALL have port frame_start, output, 1 bit: one-cycle pulse in LEFT slot cycle 0.
REQ-013 SHALL have port underrun, output, 1 bit: sticky flag, set when a frame starts with no sample available.

Function
REQ-014 SHALL implement FSM states IDLE, LEFT and RIGHT, with slot counter cnt running 0..SLOT_BITS-1.
REQ-015 IDLE SHALL hold ws_out=0 and sd_out=0, and SHALL go to LEFT with cnt=0 when enable=1.
REQ-016 LEFT SHALL go to RIGHT after cnt=SLOT_BITS-1; ws_out=0 throughout LEFT.
REQ-017 RIGHT SHALL go to LEFT with cnt=0 after cnt=SLOT_BITS-1 if enable=1, otherwise to IDLE; ws_out=1 throughout RIGHT.
REQ-018 Deasserting enable mid-frame SHALL let the current frame complete; it never truncates a slot.
REQ-019 Each slot SHALL drive sd_out=0 at cnt 0, the word MSB-first at cnt 1..NUMBER_OF_BITS, and 0 at all remaining cycles.
REQ-020 Handshake: a transfer SHALL occur when sample_valid && sample_ready; sample_ready = !holding_full, and the transfer captures the pair into holding and sets holding_full.
REQ-021 At each frame-boundary edge (entry to LEFT, cnt=0), the holding pair SHALL move to the tx registers and holding_full SHALL clear.
REQ-022 If holding is empty but a transfer occurs in the same cycle as a frame-boundary edge, the input pair SHALL go directly to the tx registers, holding SHALL stay empty, and no underrun SHALL be flagged.
REQ-023 If neither holding_full nor a same-cycle transfer exists at a frame-boundary edge, both tx words SHALL be 0 and underrun SHALL set.
REQ-024 frame_start SHALL be 1 exactly in the cycle where ws_out=0 and LEFT cnt=0 are presented.
REQ-025 ws_out and sd_out SHALL be updated together, so the ws edge and the slot's cnt-0 bit appear in the same cycle.

Reset
REQ-026 Reset SHALL force state=IDLE, cnt=0, ws_out=0, sd_out=0, frame_start=0, underrun=0, holding_full=0 (sample_ready=1) and tx registers=0.
REQ-027 Reset SHALL take priority over every other event; reset mid-frame SHALL abort the frame on the next edge.

Configuration
REQ-028 With macro TX_MONO_SUM_EN defined, at each frame boundary both tx words SHALL equal (left+right)>>>1, computed signed in NUMBER_OF_BITS+1 bits and truncated to NUMBER_OF_BITS (no overflow possible).
REQ-029 With TX_MONO_SUM_EN undefined, left and right SHALL be transmitted independently and no adder SHALL exist.

Verification (NUMBER_OF_BITS=8, SLOT_BITS=16)
REQ-030 Enable=1, one pair L=0xA5 R=0x3C -> cycles 0-15: ws=0, sd=0,1,0,1,0,0,1,0,1 then 0s; cycles 16-31: ws=1, sd=0,0,0,1,1,1,1,0,0 then 0s; frame_start at cycle 0.
REQ-031 No sample before the second frame boundary -> second frame transmits all-zero sd and underrun=1 stays set until reset.
REQ-032 Transfer asserted exactly on a boundary edge with holding empty -> pair transmitted that frame, underrun=0, sample_ready stays 1.
REQ-033 TX_MONO_SUM_EN defined: L=0x7F R=0x01 -> both slots 0x40; L=0x80 R=0x80 -> both slots 0x80; L=0x80 R=0x7F -> both slots 0xFF.
REQ-034 Enable dropped at cycle 5 of LEFT -> the full 32-cycle frame completes, then IDLE with ws=0 and sd=0.
REQ-035 Reset asserted at RIGHT cnt 7 -> next cycle all outputs at reset values, sample_ready=1, underrun=0.
